axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_pkg.sv | 24 ++
 rtl/axi_if.sv | 68 ++++++
 rtl/axi_burst_addr_gen.sv | 37 +++
 rtl/axi_mem_slave.sv | 215 +++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared burst encodings, FSM state types and size clamping for the AXI memory slave.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // A transfer size wider than the bus is treated as full bus width.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) with slave and master views.
interface axi_if #(
    parameter int unsigned ID_W_WIDTH     = 4,
    parameter int unsigned ID_R_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [ID_W_WIDTH-1:0]       AWID;
    logic [ADDR_WIDTH-1:0]       AWADDR;
    logic [7:0]                  AWLEN;
    logic [2:0]                  AWSIZE;
    logic [1:0]                  AWBURST;
    logic                        AWVALID;
    logic                        AWREADY;

    logic [AXI_DATA_WIDTH-1:0]   WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                        WLAST;
    logic                        WVALID;
    logic                        WREADY;

    logic [ID_W_WIDTH-1:0]       BID;
    logic [1:0]                  BRESP;
    logic                        BVALID;
    logic                        BREADY;

    logic [ID_R_WIDTH-1:0]       ARID;
    logic [ADDR_WIDTH-1:0]       ARADDR;
    logic [7:0]                  ARLEN;
    logic [2:0]                  ARSIZE;
    logic [1:0]                  ARBURST;
    logic                        ARVALID;
    logic                        ARREADY;

    logic [ID_R_WIDTH-1:0]       RID;
    logic [AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                  RRESP;
    logic                        RLAST;
    logic                        RVALID;
    logic                        RREADY;

    modport s (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport m (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    localparam int unsigned MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

    logic [2:0]            size_eff;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [31:0]           window;

    // Step by the (clamped) transfer size; WRAP keeps the window base and wraps the offset.
    always_comb begin
        size_eff  = clamp_size(size_i, 3'(MAX_SIZE));
        step      = ADDR_WIDTH'(1) << size_eff;
        incr_addr = addr_i + step;
        window    = (32'(len_i) + 32'd1) << size_eff;
        wrap_mask = ADDR_WIDTH'(window - 32'd1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent single-outstanding write and read burst engines over one array.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int unsigned ID_W_WIDTH     = 4,
    parameter int unsigned ID_R_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH      = 1024
) (
    input logic ACLK,
    input logic ARESET,
    axi_if.s    s
);

    localparam int unsigned NB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_t              w_state_q, w_state_d;
    logic [ID_W_WIDTH-1:0] awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic [7:0]            wcnt_q, wcnt_d;

    r_state_t              r_state_q, r_state_d;
    logic [ID_R_WIDTH-1:0] arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [7:0]            rcnt_q, rcnt_d;

    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_beat;
    logic                  r_beat;
    logic                  unused_wlast;

    assign w_idx  = awaddr_q[OFF +: IDX_W];
    assign r_idx  = araddr_q[OFF +: IDX_W];
    assign w_beat = (w_state_q == W_DATA) && s.WVALID;
    assign r_beat = (r_state_q == R_DATA) && s.RREADY;

    // Burst length comes from AWLEN alone, so WLAST carries no information here.
    assign unused_wlast = s.WLAST;

    axi_burst_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_wr_addr_gen (
        .addr_i      (awaddr_q),
        .size_i      (awsize_q),
        .len_i       (awlen_q),
        .burst_i     (awburst_q),
        .next_addr_o (w_next_addr)
    );

    axi_burst_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_rd_addr_gen (
        .addr_i      (araddr_q),
        .size_i      (arsize_q),
        .len_i       (arlen_q),
        .burst_i     (arburst_q),
        .next_addr_o (r_next_addr)
    );

    assign s.AWREADY = (w_state_q == W_IDLE);
    assign s.WREADY  = (w_state_q == W_DATA);
    assign s.BVALID  = (w_state_q == W_RESP);
    assign s.BID     = awid_q;
    assign s.BRESP   = 2'b00;

    assign s.ARREADY = (r_state_q == R_IDLE);
    assign s.RVALID  = (r_state_q == R_DATA);
    assign s.RID     = arid_q;
    assign s.RDATA   = mem_q[r_idx];
    assign s.RLAST   = (r_state_q == R_DATA) && (rcnt_q == arlen_q);
    assign s.RRESP   = 2'b00;

    // Write channel state and captured AW fields.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            wcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Write FSM: accept AW, take AWLEN+1 data beats, then hold the B response until accepted.
    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        wcnt_d    = wcnt_q;
        case (w_state_q)
            W_IDLE: begin
                if (s.AWVALID) begin
                    awid_d    = s.AWID;
                    awaddr_d  = s.AWADDR;
                    awlen_d   = s.AWLEN;
                    awsize_d  = s.AWSIZE;
                    awburst_d = s.AWBURST;
                    wcnt_d    = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    awaddr_d = w_next_addr;
                    wcnt_d   = wcnt_q + 8'd1;
                    if (wcnt_q == awlen_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s.BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Storage update: only strobed lanes of an accepted beat are written; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (w_beat) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (s.WSTRB[b]) begin
                    mem_q[w_idx][b*8 +: 8] <= s.WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Read channel state and captured AR fields.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rcnt_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Read FSM: accept AR, present ARLEN+1 beats, advancing only on RREADY.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (s.ARVALID) begin
                    arid_d    = s.ARID;
                    araddr_d  = s.ARADDR;
                    arlen_d   = s.ARLEN;
                    arsize_d  = s.ARSIZE;
                    arburst_d = s.ARBURST;
                    rcnt_d    = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_beat) begin
                    araddr_d = r_next_addr;
                    rcnt_d   = rcnt_q + 8'd1;
                    if (rcnt_q == arlen_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: drivers queue expected B/R responses, a monitor checks them.
module tb_axi_mem_slave;
    import axi_mem_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rr_toggle = 1'b0;

    always #5 clk = ~clk;

    axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) bus ();

    axi_mem_slave #(
        .ID_W_WIDTH     (4),
        .ID_R_WIDTH     (4),
        .ADDR_WIDTH     (16),
        .AXI_DATA_WIDTH (32),
        .MEM_DEPTH      (1024)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s      (bus)
    );

    r_exp_t      rq[$];
    logic [3:0]  bq[$];
    int          vectors = 0;
    int          miscompares = 0;
    time         last_w_edge = 0;
    time         first_w_edge = 0;
    time         last_ar_edge = 0;
    time         r_last_time = 0;
    logic [31:0] wd [16];
    logic [31:0] re [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake not seen within bound (t=%0t)", name, $time);
    endtask

    // Monitor: compare the head of each queue whenever the DUT presents a response; pop on handshake.
    always @(negedge clk) begin
        if (!rst && bus.RVALID) begin
            if (rq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL r_unexpected: got RDATA %08h, expected no beat", bus.RDATA);
            end else begin
                chk("rdata", 64'(bus.RDATA), 64'(rq[0].data));
                chk("rid",   64'(bus.RID),   64'(rq[0].id));
                chk("rlast", 64'(bus.RLAST), 64'(rq[0].last));
                if (bus.RREADY) begin
                    if (bus.RLAST) r_last_time = $time;
                    void'(rq.pop_front());
                end
            end
        end
        if (!rst && bus.BVALID) begin
            if (bq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected: got BID %0h, expected no response", bus.BID);
            end else begin
                chk("bid", 64'(bus.BID), 64'(bq[0]));
                if (bus.BREADY) void'(bq.pop_front());
            end
        end
    end

    initial begin
        bus.RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.RREADY = rr_toggle ? ~bus.RREADY : 1'b1;
        end
    end

    task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int unsigned n = 0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'd2; bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        @(negedge clk);
        while (!bus.AWREADY && n < 50) begin n++; @(negedge clk); end
        if (!bus.AWREADY) timeout_fail("aw_timeout");
        else begin @(posedge clk); #1; end
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int unsigned n = 0;
        bus.WDATA = d; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        @(negedge clk);
        while (!bus.WREADY && n < 50) begin n++; @(negedge clk); end
        if (!bus.WREADY) timeout_fail("w_timeout");
        else begin @(posedge clk); last_w_edge = $time; #1; end
        bus.WVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int unsigned n = 0;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd2; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        @(negedge clk);
        while (!bus.ARREADY && n < 50) begin n++; @(negedge clk); end
        if (!bus.ARREADY) timeout_fail("ar_timeout");
        else begin @(posedge clk); last_ar_edge = $time; #1; end
        bus.ARVALID = 1'b0;
    endtask

    task automatic wr(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [3:0] strb);
        bq.push_back(id);
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            w_send(wd[i], strb, i == int'(len));
            if (i == 0) first_w_edge = last_w_edge;
        end
    endtask

    task automatic rd(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                      input logic [1:0] burst);
        for (int i = 0; i <= int'(len); i++) rq.push_back('{id, re[i], i == int'(len)});
        ar_send(id, addr, len, burst);
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin @(posedge clk); n++; end
        #1;
        chk("drain", 64'(rq.size() + bq.size()), 64'd0);
        rq.delete();
        bq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0; bus.BREADY = 1'b1;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(bus.AWREADY), 64'd1);
        chk("rst_arready", 64'(bus.ARREADY), 64'd1);
        chk("rst_wready",  64'(bus.WREADY),  64'd0);
        chk("rst_bvalid",  64'(bus.BVALID),  64'd0);
        chk("rst_rvalid",  64'(bus.RVALID),  64'd0);
        chk("rst_rlast",   64'(bus.RLAST),   64'd0);
        chk("rst_bid",     64'(bus.BID),     64'd0);
        chk("rst_rid",     64'(bus.RID),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // INCR write of words 4..7, B held until BREADY
        bus.BREADY = 1'b0;
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        wr(4'd5, 16'h0010, 8'd3, BURST_INCR, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("bvalid_hold", 64'(bus.BVALID), 64'd1);
        bus.BREADY = 1'b1;
        wait_drain();

        // INCR read-back with RREADY toggling
        rr_toggle = 1'b1;
        for (int i = 0; i < 4; i++) re[i] = 32'hA0 + 32'(i);
        rd(4'd3, 16'h0010, 8'd3, BURST_INCR);
        wait_drain();
        rr_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // WRAP write from 0x18: beats land at 0x18, 0x1C, 0x10, 0x14
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
        wr(4'd6, 16'h0018, 8'd3, BURST_WRAP, 4'hF);
        wait_drain();
        re[0] = 32'hB2; re[1] = 32'hB3; re[2] = 32'hB0; re[3] = 32'hB1;
        rd(4'd4, 16'h0010, 8'd3, BURST_INCR);
        wait_drain();

        // Partial strobes over an all-ones word, then FIXED and single-beat reads
        wd[0] = 32'hFFFF_FFFF;
        wr(4'd1, 16'h0020, 8'd0, BURST_INCR, 4'hF);
        wd[0] = 32'h1122_3344;
        wr(4'd2, 16'h0020, 8'd0, BURST_INCR, 4'b0101);
        wait_drain();
        for (int i = 0; i < 3; i++) re[i] = 32'hFF22_FF44;
        rd(4'd5, 16'h0020, 8'd2, BURST_FIXED);
        wait_drain();
        rd(4'd6, 16'h0020, 8'd0, BURST_INCR);
        wait_drain();

        // Concurrent 8-beat write and 8-beat read on disjoint words, no bubbles expected
        for (int i = 0; i < 8; i++) wd[i] = 32'hD0 + 32'(i);
        wr(4'd8, 16'h0200, 8'd7, BURST_INCR, 4'hF);
        wait_drain();
        for (int i = 0; i < 8; i++) wd[i] = 32'hC0 + 32'(i);
        for (int i = 0; i < 8; i++) re[i] = 32'hD0 + 32'(i);
        fork
            wr(4'd9, 16'h0100, 8'd7, BURST_INCR, 4'hF);
            rd(4'd10, 16'h0200, 8'd7, BURST_INCR);
        join
        wait_drain();
        chk("w_no_stall", 64'(last_w_edge - first_w_edge), 64'd70);
        chk("r_no_stall", 64'(r_last_time - last_ar_edge), 64'd75);

        // Same-word write and read in the same cycle: read sees old data, next read sees new
        wd[0] = 32'hE0;
        re[0] = 32'hC0;
        fork
            wr(4'd11, 16'h0100, 8'd0, BURST_INCR, 4'hF);
            rd(4'd12, 16'h0100, 8'd0, BURST_INCR);
        join
        wait_drain();
        re[0] = 32'hE0;
        rd(4'd13, 16'h0100, 8'd0, BURST_INCR);
        wait_drain();

        // Reset pulse while beat 2 of a 4-beat write is offered
        for (int i = 0; i < 4; i++) wd[i] = 32'hF0 + 32'(i);
        wr(4'd14, 16'h0300, 8'd3, BURST_INCR, 4'hF);
        wait_drain();
        aw_send(4'd7, 16'h0300, 8'd3, BURST_INCR);
        w_send(32'h10, 4'hF, 1'b0);
        bus.WDATA = 32'h11; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wready",  64'(bus.WREADY),  64'd0);
        chk("midrst_awready", 64'(bus.AWREADY), 64'd1);
        chk("midrst_bvalid",  64'(bus.BVALID),  64'd0);
        bus.WVALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wready_hold", 64'(bus.WREADY), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        re[0] = 32'h10; re[1] = 32'hF1; re[2] = 32'hF2; re[3] = 32'hF3;
        rd(4'd15, 16'h0300, 8'd3, BURST_INCR);
        wait_drain();
        wd[0] = 32'h55;
        wr(4'd9, 16'h0304, 8'd0, BURST_INCR, 4'hF);
        wait_drain();
        re[1] = 32'h55;
        rd(4'd1, 16'h0300, 8'd3, BURST_INCR);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
